instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the MIPS datapath. Accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake, packs them into 32-bit MIPS words using the same opcode/funct map the control unit decodes, and writes them to consecutive instruction-memory addresses. It sits between the test/boot sequencer and the instruction memory write port, and produces exactly the encodings the control unit consumes.

---
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit words and writes them to
// consecutive instruction-memory addresses, one word per two cycles.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        OP,
   input  logic [4:0]        RS,
   input  logic [4:0]        RT,
   input  logic [4:0]        RD,
   input  logic [15:0]       IMM,
   output logic              IMEM_WE,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic [31:0]       IMEM_WDATA,
   output logic              FULL,
   output logic [ADDR_W:0]   COUNT
);

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LastAddr = '1;

   typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [31:0]         enc_word;

   // Same opcode/funct map the control unit decodes.
   always_comb begin
      enc_word = '0;
      unique case (OP)
         3'd0:    enc_word = {6'b000000, RS, RT, RD, 5'b00000, 6'b100000};
         3'd1:    enc_word = {6'b000000, RS, RT, RD, 5'b00000, 6'b100010};
         3'd2:    enc_word = {6'b000000, RS, RT, RD, 5'b00000, 6'b100100};
         3'd3:    enc_word = {6'b000000, RS, RT, RD, 5'b00000, 6'b100101};
         3'd4:    enc_word = {6'b000000, RS, RT, RD, 5'b00000, 6'b101010};
         3'd5:    enc_word = {6'b001000, RS, RT, IMM};
         3'd6:    enc_word = {6'b011001, RS, RT, IMM};
         3'd7:    enc_word = {6'b011000, RS, RT, IMM};
         default: enc_word = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      if (CLR) begin
         // A write in flight still completes this cycle; only its bookkeeping is dropped.
         state_d = StIdle;
         addr_d  = BaseAddr;
         count_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (IN_VALID) begin
                  wdata_d = enc_word;
                  state_d = StWrite;
               end
            end
            StWrite: begin
               count_d = count_q + 1'b1;
               if (addr_q == LastAddr) begin
                  state_d = StFull;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StIdle;
               end
            end
            StFull:  state_d = StFull;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         addr_q  <= BaseAddr;
         wdata_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
      end
   end

   assign IN_READY   = (state_q == StIdle);
   assign IMEM_WE    = (state_q == StWrite);
   assign FULL       = (state_q == StFull);
   assign IMEM_ADDR  = addr_q;
   assign IMEM_WDATA = wdata_q;
   assign COUNT      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked against a
// transaction-level model of the loader (word count, full flag, pending write).
module tb_instr_encoder;

   localparam int unsigned AW   = 3;
   localparam int unsigned BASE = 0;
   localparam int unsigned CAP  = (1 << AW) - BASE;

   logic          clk;
   logic          rst_n, clr, in_valid;
   logic [2:0]    op;
   logic [4:0]    rs, rt, rd;
   logic [15:0]   imm;
   logic          in_ready, imem_we, full;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: words written, write pending this cycle, full flag, last latched word.
   int unsigned m_count;
   bit          m_pending;
   bit          m_full;
   logic [31:0] m_word;

   instr_encoder #(
      .ADDR_W    (AW),
      .BASE_ADDR (BASE)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .CLR        (clr),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready),
      .OP         (op),
      .RS         (rs),
      .RT         (rt),
      .RD         (rd),
      .IMM        (imm),
      .IMEM_WE    (imem_we),
      .IMEM_ADDR  (imem_addr),
      .IMEM_WDATA (imem_wdata),
      .FULL       (full),
      .COUNT      (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int unsigned o, input int unsigned s,
                                            input int unsigned t, input int unsigned d,
                                            input int unsigned i);
      int unsigned funct [5] = '{32, 34, 36, 37, 42};
      int unsigned opc   [3] = '{8, 25, 24};
      if (o < 5) return 32'((s << 21) | (t << 16) | (d << 11) | funct[o]);
      return 32'((opc[o-5] << 26) | (s << 21) | (t << 16) | i);
   endfunction

   // Apply the inputs currently driven to the model, as the coming edge will.
   task automatic model_edge();
      if (!rst_n) begin
         m_count = 0; m_pending = 0; m_full = 0; m_word = '0;
      end else if (clr) begin
         m_count = 0; m_pending = 0; m_full = 0;
      end else if (m_pending) begin
         m_pending = 0;
         m_count++;
         if (m_count == CAP) m_full = 1;
      end else if (!m_full && in_valid) begin
         m_word    = ref_word(op, rs, rt, rd, imm);
         m_pending = 1;
      end
   endtask

   task automatic compare_all();
      int unsigned exp_addr;
      exp_addr = m_full ? (1 << AW) - 1 : BASE + m_count;
      check_val("in_ready", 32'(in_ready), 32'(!m_pending && !m_full));
      check_val("imem_we", 32'(imem_we), 32'(m_pending));
      check_val("full", 32'(full), 32'(m_full));
      check_val("count", 32'(count), m_count);
      check_val("imem_addr", 32'(imem_addr), exp_addr);
      check_val("imem_wdata", imem_wdata, m_word);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_req(input int unsigned o, input int unsigned s, input int unsigned t,
                          input int unsigned d, input int unsigned i);
      op = 3'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i);
   endtask

   task automatic rand_fields();
      set_req($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 65535));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
      set_req(0, 0, 0, 0, 0);
      m_count = 0; m_pending = 0; m_full = 0; m_word = '0;
      @(negedge clk);
      do_reset();
      check_val("reset_ready", 32'(in_ready), 32'd1);
      check_val("reset_wdata", imem_wdata, 32'd0);

      // Single ADD
      in_valid = 1'b1; set_req(0, 1, 2, 3, 0);
      tick();
      in_valid = 1'b0; set_req(7, 31, 31, 31, 16'hffff);
      check_val("add_we", 32'(imem_we), 32'd1);
      check_val("add_word", imem_wdata, 32'h0022_1820);
      check_val("add_addr", 32'(imem_addr), 32'd0);
      tick();
      check_val("add_count", 32'(count), 32'd1);
      check_val("add_next_addr", 32'(imem_addr), 32'd1);

      // Back-to-back SLT then ADDI with valid held high
      do_reset();
      in_valid = 1'b1; set_req(4, 5, 6, 7, 0);
      tick();
      check_val("slt_word", imem_wdata, 32'h00A6_382A);
      check_val("slt_ready", 32'(in_ready), 32'd0);
      set_req(5, 1, 2, 0, 5);
      tick();
      tick();
      check_val("addi_word", imem_wdata, 32'h2022_0005);
      check_val("addi_addr", 32'(imem_addr), 32'd1);
      check_val("addi_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();

      // LHI / LOI
      in_valid = 1'b1; set_req(6, 0, 4, 0, 16'hABCD);
      tick();
      check_val("lhi_word", imem_wdata, 32'h6404_ABCD);
      set_req(7, 0, 4, 0, 16'hABCD);
      tick();
      tick();
      check_val("loi_word", imem_wdata, 32'h6004_ABCD);
      in_valid = 1'b0;
      tick();

      // Fill to FULL with continuous requests
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !full; i++) begin
         rand_fields();
         tick();
      end
      check_val("fill_full", 32'(full), 32'd1);
      check_val("fill_count", 32'(count), 32'd8);
      check_val("fill_addr", 32'(imem_addr), 32'd7);
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         tick();
      end
      check_val("full_ignores", 32'(count), 32'd8);

      // CLR out of FULL, then a request lands at address 0
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_val("clr_full", 32'(full), 32'd0);
      check_val("clr_ready", 32'(in_ready), 32'd1);
      set_req(1, 9, 10, 11, 0);
      tick();
      in_valid = 1'b0;
      check_val("after_clr_addr", 32'(imem_addr), 32'd0);
      tick();

      // CLR during a WRITE cycle at a nonzero address
      in_valid = 1'b1; set_req(2, 3, 4, 5, 0);
      tick();
      in_valid = 1'b0;
      clr = 1'b1;
      check_val("clrw_addr", 32'(imem_addr), 32'd1);
      tick();
      clr = 1'b0;
      check_val("clrw_after_addr", 32'(imem_addr), 32'd0);
      check_val("clrw_after_count", 32'(count), 32'd0);

      // CLR in IDLE with a valid request: not accepted
      clr = 1'b1; in_valid = 1'b1;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      check_val("clr_idle_we", 32'(imem_we), 32'd0);

      // Reset during a WRITE cycle
      in_valid = 1'b1; set_req(3, 1, 1, 1, 0);
      tick();
      in_valid = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("rstw_wdata", imem_wdata, 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_fields();
         in_valid = ($urandom_range(0, 9) < 7);
         clr      = ($urandom_range(0, 19) == 0);
         rst_n    = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
